nios_button_pio: RTL and testbench
==================================

# nios_button_pio

Parametrised Avalon-MM pushbutton/switch input port for the Nios system, the next generation of the single-bit pushbutton PIO. Supports `WIDTH` channels, with per-channel input synchronisation and debounce. Edge capture is selectable (rising, falling or any), with per-bit write-1-to-clear and an interrupt mask. It drives a level-sensitive `irq` to the Nios interrupt controller.

## Interface
- `WIDTH`, 4: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required before the debounced value changes. 0 bypasses the debounce.
- `EDGE_TYPE`, 1: 0 = rising, 1 = falling, 2 = any edge, detected on the debounced value.
- `RESET_LEVEL`, all ones: reset value of the synchronisers and debounced state (buttons released, active-low).
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; reset 0.
- `in_port`  in  WIDTH  asynchronous button inputs.
- `irq`  out  1  `|(edge_capture & irq_mask)`; reset 0.

## Operation
- Register map (unused upper bits read 0):
  - addr 0 DATA (RO): debounced value.
  - addr 1 RAW (RO): synchronised, undebounced value.
  - addr 2 IRQ_MASK (RW): reset 0.
  - addr 3 EDGE_CAPTURE (R/W1C): reset 0.
- Writes to addr 0/1 are ignored.
- A write occurs when `chipselect && !write_n`. Only `writedata[WIDTH-1:0]` is used.
- Read path: `readdata` is registered every cycle from `address`, independent of `chipselect`.
- Per channel:
  - Two-flop synchroniser `s1 -> s2`.
  - Debounce counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)` (min 1).
- Debounce state update on each clock edge:
  - `s2 == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any glitch back to `stable` restarts the count.
- `DEBOUNCE_CYCLES == 0`: `stable = s2` combinationally; no counter.
- Edge detect: `prev <= stable` each cycle.
  - rise = `stable & ~prev`.
  - fall = `~stable & prev`.
  - any = `stable ^ prev`.
- Edge capture, per bit:
  - A detected edge sets the bit.
  - Writing 1 to addr 3 clears the bit.
  - Simultaneous set and clear: set wins, so no event is lost.
  - Writing 0 leaves the bit unchanged.
- `irq` is combinational from the `edge_capture` and `irq_mask` registers (glitch-free). A mask change affects `irq` in the cycle after the write.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
  - `s1`/`s2`/`stable`/`prev` reset to `RESET_LEVEL`, so no spurious edge at reset release if inputs sit at the released level.
  - Counters reset to 0.

## Timing
- Input change sampled at edge t:
  - `s2` reflects it after edge t+1.
  - `stable` updates at edge t+1+`DEBOUNCE_CYCLES`, if the input is held.
  - `edge_capture` bit sets at edge t+2+`DEBOUNCE_CYCLES`.
  - `irq` asserts in the same cycle as the `edge_capture` set.
- Read latency: `readdata` is valid the cycle after `address` is presented (1 wait-state-free cycle; the bus is configured with readLatency 1).
- W1C and mask writes take effect at the clock edge of the write cycle.
- Readback in the following cycle returns the updated value.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles. Shorter pulses never reach DATA.

## Structure
- Package `nios_button_pio_pkg` holds:
  - `ADDR_DATA`=0, `ADDR_RAW`=1, `ADDR_IRQ_MASK`=2, `ADDR_EDGE_CAPTURE`=3.
  - `EDGE_RISING`=0, `EDGE_FALLING`=1, `EDGE_ANY`=2.
- Sub-module `nios_button_debounce`:
  - Contains one channel: synchroniser, counter and stable register.
  - Parameters `DEBOUNCE_CYCLES`, `RESET_BIT`.
  - Outputs `raw` and `stable`.
  - Generate-instantiated `WIDTH` times.
- The top level holds the edge detect, registers, read mux and `irq`.

## Test plan
All scenarios use `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `EDGE_TYPE`=1.
- Reset:
  - Stimulus: hold `reset_n`=0 with `in_port`=4'hF, then release.
  - Required: `readdata`=0 and `irq`=0 during reset; DATA reads 4'hF; EDGE_CAPTURE reads 0 for 20 cycles.
- Debounce accept:
  - Stimulus: drive `in_port[0]`=0 at edge t and hold.
  - Required: DATA reads 4'hE from edge t+5; EDGE_CAPTURE=4'h1 at edge t+6.
  - Stimulus: with IRQ_MASK=4'h1, repeat the press.
  - Required: `irq`=1 in that same cycle.
- Glitch reject:
  - Stimulus: drive `in_port[1]` low for 3 cycles, high 1, low 3, then release.
  - Required: DATA stays 4'hF; EDGE_CAPTURE stays 0; RAW shows the glitches.
- W1C and race:
  - Stimulus: capture=4'h3, then write 4'h1 to addr 3.
  - Required: reads 4'h2.
  - Stimulus: write 4'h2 in the same cycle a new ch1 falling edge is detected.
  - Required: bit stays 1.
- Mask:
  - Stimulus: capture=4'h4 with IRQ_MASK=0.
  - Required: `irq`=0.
  - Stimulus: write mask 4'h4.
  - Required: `irq`=1 next cycle.
  - Stimulus: write 4'h4 to addr 3.
  - Required: `irq`=0 next cycle.
- Edge modes:
  - Stimulus: with `EDGE_TYPE`=0, press then release ch2.
  - Required: capture is set only on the release.
  - Stimulus: with `EDGE_TYPE`=2, press then release.
  - Required: capture is set on both edges (clear in between).
  - Stimulus: with `DEBOUNCE_CYCLES`=0.
  - Required: capture occurs 3 edges after the input change.

Source files
------------

// File: rtl/nios_button_pio_pkg.sv
// Shared register addresses, edge-mode encodings and sizing helper for the
// Nios pushbutton/switch PIO.
package nios_button_pio_pkg;

   localparam logic [1:0] ADDR_DATA         = 2'd0;
   localparam logic [1:0] ADDR_RAW          = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // Debounce counter width; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/nios_button_debounce.sv
// One input channel: two-flop synchroniser followed by a stability counter
// that only lets a level through after DEBOUNCE_CYCLES consistent samples.
module nios_button_debounce
   import nios_button_pio_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic RESET_BIT       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic raw,
   output logic stable
);

   logic s1;
   logic s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= RESET_BIT;
         s2 <= RESET_BIT;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

   assign raw = s2;

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable = s2;
      end else begin : g_count
         localparam int CW = cnt_width(DEBOUNCE_CYCLES);
         localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt;
         logic          stable_q;

         // Any sample that agrees with the accepted level restarts the count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt      <= '0;
               stable_q <= RESET_BIT;
            end else if (s2 == stable_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               stable_q <= s2;
               cnt      <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         assign stable = stable_q;
      end
   endgenerate

endmodule

// File: rtl/nios_button_pio.sv
// Avalon-MM pushbutton/switch PIO: per-channel debounce, selectable edge
// capture with write-1-to-clear, interrupt mask and level irq.
module nios_button_pio
   import nios_button_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 1000,
   parameter int               EDGE_TYPE       = EDGE_FALLING,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_p1;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] clr_bits;
   logic [31:0]      rd_next;
   logic             wr_en;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      nios_button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_BIT      (RESET_LEVEL[g])
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .din    (in_port[g]),
         .raw    (raw[g]),
         .stable (stable[g])
      );
   end

   if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
   end

   assign wr_en    = chipselect && !write_n;
   assign wr_data  = writedata[WIDTH-1:0];
   assign clr_bits = (wr_en && address == ADDR_EDGE_CAPTURE) ? wr_data : '0;

   always_comb begin
      edge_det = '0;
      case (EDGE_TYPE)
         EDGE_RISING:  edge_det = stable & ~stable_p1;
         EDGE_FALLING: edge_det = ~stable & stable_p1;
         default:      edge_det = stable ^ stable_p1;
      endcase
   end

   // Edge detect / register stage; a detected edge beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_p1    <= RESET_LEVEL;
         edge_capture <= '0;
         irq_mask     <= '0;
      end else begin
         stable_p1    <= stable;
         edge_capture <= edge_det | (edge_capture & ~clr_bits);
         if (wr_en && address == ADDR_IRQ_MASK) begin
            irq_mask <= wr_data;
         end
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:     rd_next[WIDTH-1:0] = stable;
         ADDR_RAW:      rd_next[WIDTH-1:0] = raw;
         ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
         default:       rd_next[WIDTH-1:0] = edge_capture;
      endcase
   end

   // Read stage: one cycle of latency regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_next;
      end
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_button_pio.sv
// Directed bench for nios_button_pio: four instances (falling, rising, any,
// no-debounce) share the bus and inputs; each is observed on its own outputs.
module tb_nios_button_pio;
   import nios_button_pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;

   logic [31:0] rd_fall, rd_rise, rd_any, rd_d0;
   logic        irq_fall, irq_rise, irq_any, irq_d0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_FALLING), .RESET_LEVEL(4'hF)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd_fall), .in_port(in_port), .irq(irq_fall));

   nios_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING), .RESET_LEVEL(4'hF)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd_rise), .in_port(in_port), .irq(irq_rise));

   nios_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_ANY), .RESET_LEVEL(4'hF)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd_any), .in_port(in_port), .irq(irq_any));

   nios_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_FALLING), .RESET_LEVEL(4'hF)) u_d0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd_d0), .in_port(in_port), .irq(irq_d0));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic read_reg(input logic [1:0] a);
      address = a;
      tick();
   endtask

   logic [3:0] glitch_seq [12];

   initial begin
      glitch_seq = '{4'hD, 4'hD, 4'hD, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

      reset_n    = 1'b0;
      in_port    = 4'hF;
      address    = ADDR_EDGE_CAPTURE;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // Reset
      ticks(3);
      check("rst_readdata", rd_fall, 32'h0);
      check("rst_irq", {31'h0, irq_fall}, 32'h0);
      reset_n = 1'b1;
      read_reg(ADDR_DATA);
      check("rst_data", rd_fall, 32'hF);
      address = ADDR_EDGE_CAPTURE;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rst_cap_idle", rd_fall, 32'h0);
      end

      // Debounce accept on ch0
      address = ADDR_DATA;
      in_port = 4'hE;
      ticks(5);
      check("deb_data_early", rd_fall, 32'hF);
      ticks(2);
      check("deb_data_accept", rd_fall, 32'hE);
      read_reg(ADDR_EDGE_CAPTURE);
      check("deb_cap", rd_fall, 32'h1);
      check("deb_irq_masked", {31'h0, irq_fall}, 32'h0);
      in_port = 4'hF;
      ticks(8);
      bus_write(ADDR_EDGE_CAPTURE, 32'hF);
      read_reg(ADDR_EDGE_CAPTURE);
      check("deb_cap_cleared", rd_fall, 32'h0);

      // Same press with ch0 unmasked: irq rises with the capture
      bus_write(ADDR_IRQ_MASK, 32'h1);
      in_port = 4'hE;
      ticks(6);
      check("deb_irq_before", {31'h0, irq_fall}, 32'h0);
      tick();
      check("deb_irq_at_cap", {31'h0, irq_fall}, 32'h1);
      in_port = 4'hF;
      ticks(8);
      bus_write(ADDR_EDGE_CAPTURE, 32'hF);
      bus_write(ADDR_IRQ_MASK, 32'h0);

      // Glitch reject on ch1; RAW lags the pin by two edges plus the read register
      address = ADDR_RAW;
      tick();
      for (int i = 0; i < 12; i++) begin
         in_port = glitch_seq[i];
         tick();
         check("glitch_raw", rd_fall, (i >= 2) ? {28'h0, glitch_seq[i-2]} : 32'hF);
      end
      ticks(6);
      read_reg(ADDR_DATA);
      check("glitch_data", rd_fall, 32'hF);
      read_reg(ADDR_EDGE_CAPTURE);
      check("glitch_cap", rd_fall, 32'h0);

      // W1C and set-beats-clear race
      in_port = 4'hC;
      ticks(8);
      in_port = 4'hF;
      ticks(8);
      read_reg(ADDR_EDGE_CAPTURE);
      check("w1c_cap3", rd_fall, 32'h3);
      bus_write(ADDR_EDGE_CAPTURE, 32'h1);
      read_reg(ADDR_EDGE_CAPTURE);
      check("w1c_clear_bit0", rd_fall, 32'h2);
      bus_write(ADDR_EDGE_CAPTURE, 32'h0);
      read_reg(ADDR_EDGE_CAPTURE);
      check("w1c_write0", rd_fall, 32'h2);
      bus_write(ADDR_EDGE_CAPTURE, 32'hF);
      read_reg(ADDR_EDGE_CAPTURE);
      check("w1c_clear_all", rd_fall, 32'h0);
      in_port = 4'hD;
      ticks(6);
      bus_write(ADDR_EDGE_CAPTURE, 32'h2);
      read_reg(ADDR_EDGE_CAPTURE);
      check("w1c_race", rd_fall, 32'h2);
      in_port = 4'hF;
      ticks(8);

      // Mask
      bus_write(ADDR_EDGE_CAPTURE, 32'hF);
      in_port = 4'hB;
      ticks(8);
      check("mask_irq_off", {31'h0, irq_fall}, 32'h0);
      read_reg(ADDR_EDGE_CAPTURE);
      check("mask_cap4", rd_fall, 32'h4);
      bus_write(ADDR_IRQ_MASK, 32'h4);
      check("mask_irq_on", {31'h0, irq_fall}, 32'h1);
      read_reg(ADDR_IRQ_MASK);
      check("mask_readback", rd_fall, 32'h4);
      bus_write(ADDR_EDGE_CAPTURE, 32'h4);
      check("mask_irq_cleared", {31'h0, irq_fall}, 32'h0);
      in_port = 4'hF;
      ticks(8);

      // Edge modes and zero-debounce on ch2
      bus_write(ADDR_IRQ_MASK, 32'hF);
      bus_write(ADDR_EDGE_CAPTURE, 32'hF);
      in_port = 4'hB;
      ticks(2);
      check("d0_irq_before", {31'h0, irq_d0}, 32'h0);
      tick();
      check("d0_irq_at_cap", {31'h0, irq_d0}, 32'h1);
      ticks(3);
      check("any_press_before", {31'h0, irq_any}, 32'h0);
      tick();
      check("any_press", {31'h0, irq_any}, 32'h1);
      check("rise_press", {31'h0, irq_rise}, 32'h0);
      check("fall_press", {31'h0, irq_fall}, 32'h1);
      ticks(3);
      bus_write(ADDR_EDGE_CAPTURE, 32'hF);
      in_port = 4'hF;
      ticks(6);
      check("rise_rel_before", {31'h0, irq_rise}, 32'h0);
      check("any_rel_before", {31'h0, irq_any}, 32'h0);
      tick();
      check("rise_release", {31'h0, irq_rise}, 32'h1);
      check("any_release", {31'h0, irq_any}, 32'h1);
      check("fall_release", {31'h0, irq_fall}, 32'h0);
      check("d0_release", {31'h0, irq_d0}, 32'h0);
      ticks(2);
      read_reg(ADDR_EDGE_CAPTURE);
      check("rise_cap", rd_rise, 32'h4);
      check("any_cap", rd_any, 32'h4);

      // Asynchronous reset mid-operation
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_readdata", rd_rise, 32'h0);
      check("async_rst_irq", {31'h0, irq_rise}, 32'h0);
      tick();
      reset_n = 1'b1;
      read_reg(ADDR_EDGE_CAPTURE);
      check("async_rst_cap", rd_rise, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
